// File: rtl/alu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit ALU datapath: owns the PC, the
// instruction register and the Z/N flag registers, and decodes all side-port strobes.
module alu_control_unit #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    pc,
    output logic [1:0]         rf_ra,
    output logic [1:0]         rf_rb,
    output logic [1:0]         rf_wa,
    output logic               rf_we,
    output logic               rf_wsel,
    output logic [3:0]         alu_sel,
    output logic               alu_bsel,
    output logic [7:0]         imm,
    input  logic [1:0]         alu_flag,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    output logic               dmem_we,
    output logic [7:0]         dmem_addr,
    output logic               halted,
    output logic [1:0]         dbg_state
);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SHR   = 4'b0101;
    localparam logic [3:0] OP_OUT   = 4'b0110;
    localparam logic [3:0] OP_IN    = 4'b0111;
    localparam logic [3:0] OP_MOV   = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_JMP   = 4'b1011;
    localparam logic [3:0] OP_BZ    = 4'b1100;
    localparam logic [3:0] OP_BN    = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               z_q;
    logic               n_q;

    logic [3:0]      op;
    logic [PC_W-1:0] imm_pc;
    logic [PC_W-1:0] pc_inc;
    logic            flag_op;
    logic            wr_op;
    logic            exec_live;

    assign op      = instr_q[15:12];
    assign imm_pc  = PC_W'(instr_q[7:0]);
    assign pc_inc  = pc_q + PC_W'(1);
    assign flag_op = (op >= OP_ADD) && (op <= OP_SHR);
    assign wr_op   = flag_op || (op == OP_MOV) || (op == OP_LDI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_data;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: state_q <= S_EXEC;
                S_EXEC: begin
                    // IN holds here until the input port hands over a word
                    if (!((op == OP_IN) && !in_valid)) begin
                        state_q <= S_FETCH;
                        if (flag_op) begin
                            z_q <= alu_flag[1];
                            n_q <= alu_flag[0];
                        end
                        case (op)
                            OP_JMP:  pc_q <= imm_pc;
                            OP_BZ:   pc_q <= z_q ? imm_pc : pc_inc;
                            OP_BN:   pc_q <= n_q ? imm_pc : pc_inc;
                            OP_HALT: state_q <= S_HALT;
                            default: pc_q <= pc_inc;
                        endcase
                    end
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // rst masks every strobe at once so an in-flight instruction never commits;
    // the IN write strobe is the in_valid/in_ready handshake itself.
    assign exec_live = (state_q == S_EXEC) && !rst;

    always_comb begin
        alu_sel = 4'b0000;
        if (state_q == S_EXEC) begin
            if ((op >= OP_ADD) && (op <= OP_STORE)) begin
                alu_sel = op;
            end else if (op == OP_LDI) begin
                alu_sel = OP_MOV;
            end
        end
    end

    assign imem_req  = (state_q == S_FETCH) && !rst;
    assign rf_we     = exec_live && (wr_op || ((op == OP_IN) && in_valid));
    assign rf_wsel   = (state_q == S_EXEC) && (op == OP_IN);
    assign in_ready  = exec_live && (op == OP_IN);
    assign out_valid = exec_live && (op == OP_OUT);
    assign dmem_we   = exec_live && (op == OP_STORE);
    assign alu_bsel  = (op == OP_LDI);
    assign rf_ra     = instr_q[11:10];
    assign rf_rb     = instr_q[9:8];
    assign rf_wa     = instr_q[11:10];
    assign imm       = instr_q[7:0];
    assign dmem_addr = instr_q[7:0];
    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;
    assign dbg_state = state_q;

endmodule
